vending_machine_gen: RTL
========================

# vending_machine_gen

Parametrised next-generation vending machine controller for the vending design family. It accepts a coin deposit and an item request through a valid/ready handshake and prices the order. It then dispenses change greedily from its internal coin store, largest coin first. Coin-count, item-count and value widths are generics, and the initial coin store is set by parameters. A completion pulse is added, and per-item stock tracking can be compiled in.

## Interface
- COIN_W, 6, width of every coin-count input, output and store counter
- NUM_W, 3, width of item number fields
- VAL_W, 13, width of value arithmetic; must be ≥ bits for max(66·(2^COIN_W−1), 100·(2^NUM_W−1))
- INIT_A / INIT_B / INIT_C / INIT_D, 5 / 30 / 10 / 20, coin store contents after reset
- STOCK_INIT, 7, per-item stock after reset (only with VENDING_STOCK_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in ON
- coin_in_a..coin_in_d  in  COIN_W each  deposited coin counts
- item_type_in  in  2  requested item type
- item_number_in  in  NUM_W  requested quantity
- force_in  in  1  serve as many items as affordable
- coin_out_a..coin_out_d  out  COIN_W each  change coin counts
- item_type_out  out  2  served item type
- item_number_out  out  NUM_W  served quantity
- service_type_out  out  2  OFF=00, ON=01, BUSY=10
- done  out  1  one-cycle pulse when result is valid

## Operation
- Clock and reset: clock clk; reset reset, synchronous, active-low.
- Reset values: all coin_out 0, item_type_out 0, item_number_out 0, service_type_out ON, done 0. Coin store is set to INIT_*.
- Coin values: A=50, B=10, C=5, D=1. Item costs: A=15, B=25, C=75, D=100.
- ON, accept condition: a request is accepted when req_valid=1 and item_number_in≠0. A request with quantity 0 is ignored.
- ON, on accept:
  - Clear coin_out.
  - Latch type, number and force.
  - Add the deposit to the store, saturating each counter at 2^COIN_W−1.
  - inputValue = Σ value·count; serviceValue = number·cost.
  - Go to BUSY/PRICE.
- BUSY/PRICE, one cycle per evaluation:
  - If inputValue ≥ serviceValue: serviceValue ← inputValue − serviceValue, go to CHANGE.
  - Else, with force: item_number_out −1 and serviceValue −cost; stay in PRICE. Quantity 0 always resolves to a full refund.
  - Else, without force: serviceValue ← inputValue, item_number_out ← 0, go to CHANGE.
- BUSY/CHANGE, one cycle per step; the current coin type starts at A:
  - If serviceValue ≥ coin value and store>0: coin_out+1, store−1, serviceValue−value.
  - If serviceValue ≥ coin value and store=0, or if serviceValue < coin value: advance to the next coin type.
- CHANGE, coin D:
  - If serviceValue = 0: go to OFF and assert done.
  - If serviceValue>0 and store D=0, this is a change failure:
    - Return all coin_out to the store and clear coin_out.
    - Restart the coin type at A.
    - With force: item_number_out −1 and serviceValue ← returned value + residue + one item cost.
    - Without force: serviceValue ← inputValue, item_number_out ← 0.
- OFF: outputs hold for exactly one cycle, then the block returns to ON.
- Reset takes priority in every state. A reset mid-transaction discards the deposit and restores INIT_*.

## Timing
- Outputs are registered; the cost is one cycle per state step.
- Accept cycle → PRICE ≥1 cycle → CHANGE (one cycle per coin dispensed plus one per coin-type advance) → OFF.
- done is high during the OFF cycle only. Outputs are stable from that cycle until the next accept.
- req_ready = (service_type_out==ON). Requests presented in other states are not buffered.

## Configuration
- VENDING_STOCK_EN defined:
  - Four NUM_W stock counters are reset to STOCK_INIT.
  - On accept, the latched number is min(request, stock). If stock is 0, the result is a full refund with item_number_out 0.
  - Stock is decremented by item_number_out in the OFF cycle.
- VENDING_STOCK_EN undefined: unlimited stock; no counters exist.

## Structure
- Package vending_pkg: service-type, coin-type and item-type enums; coin values; item costs; a cost-lookup function.
- Sub-module vending_change_unit: the greedy per-coin dispense step, covering the store counters, coin_out increments and the return on failure.
- The top level holds the state machine and the pricing logic.

## Test plan
- Reset: outputs all 0, service ON, req_ready 1, done 0; a request with quantity 0 gets no accept.
- 2×item A, 1 coin A (50 vs 30): change 20 → coin_out_b=2, item_number_out=2, done pulses once, back to ON next cycle.
- 1×item D, 1 coin A, no force: full refund coin_out_a=1, item_number_out=0.
- 3×item B, 2 coin B + 6 coin C (50), force: item_number_out=2, no change, coin_out all 0.
- Change failure, INIT_B=INIT_C=INIT_D=0, 1×item A with 2 coin B, no force: refund coin_out_b=2, item_number_out=0.
- Reset asserted mid-CHANGE → next cycle service ON, coin_out 0. With VENDING_STOCK_EN and STOCK_INIT=7: 7×A then 1×A → second result item_number_out=0 with full refund.

Source files
------------

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared enums, coin values and item costs for the vending controller
package vending_pkg;

    typedef enum logic [1:0] {SVC_OFF = 2'b00, SVC_ON = 2'b01, SVC_BUSY = 2'b10} serviceType_t;
    typedef enum logic [1:0] {COIN_A = 2'd0, COIN_B = 2'd1, COIN_C = 2'd2, COIN_D = 2'd3} coinType_t;
    typedef enum logic [1:0] {ITEM_A = 2'd0, ITEM_B = 2'd1, ITEM_C = 2'd2, ITEM_D = 2'd3} itemType_t;
    typedef enum logic [1:0] {ST_ON, ST_PRICE, ST_CHANGE, ST_OFF} state_t;

    localparam logic [5:0] VALUE_A = 6'd50;
    localparam logic [5:0] VALUE_B = 6'd10;
    localparam logic [5:0] VALUE_C = 6'd5;
    localparam logic [5:0] VALUE_D = 6'd1;

    localparam logic [6:0] COST_A = 7'd15;
    localparam logic [6:0] COST_B = 7'd25;
    localparam logic [6:0] COST_C = 7'd75;
    localparam logic [6:0] COST_D = 7'd100;

    function automatic logic [5:0] coinValue(input coinType_t c);
        case (c)
            COIN_A:  coinValue = VALUE_A;
            COIN_B:  coinValue = VALUE_B;
            COIN_C:  coinValue = VALUE_C;
            default: coinValue = VALUE_D;
        endcase
    endfunction

    function automatic logic [6:0] itemCost(input itemType_t t);
        case (t)
            ITEM_A:  itemCost = COST_A;
            ITEM_B:  itemCost = COST_B;
            ITEM_C:  itemCost = COST_C;
            default: itemCost = COST_D;
        endcase
    endfunction

endpackage

// File: rtl/vending_change_unit.sv
// rtl/vending_change_unit.sv - coin store, greedy dispense step and return-on-failure
module vending_change_unit
    import vending_pkg::*;
#(
    parameter int COIN_W = 6,
    parameter int VAL_W  = 13,
    parameter int INIT_A = 5,
    parameter int INIT_B = 30,
    parameter int INIT_C = 10,
    parameter int INIT_D = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [3:0][COIN_W-1:0] deposit,
    input  logic                   step,
    input  logic                   giveBack,
    input  coinType_t              coinSel,
    input  logic [VAL_W-1:0]       serviceValue,
    output logic                   dispense,
    output logic [3:0][COIN_W-1:0] coinOut,
    output logic [VAL_W-1:0]       returnedValue
);

    logic [3:0][COIN_W-1:0] store;
    logic [3:0][COIN_W-1:0] initStore;
    logic [3:0][COIN_W:0]   depositSum;

    assign initStore = {COIN_W'(INIT_D), COIN_W'(INIT_C), COIN_W'(INIT_B), COIN_W'(INIT_A)};

    assign dispense = step && (serviceValue >= VAL_W'(coinValue(coinSel)))
                      && (store[coinSel] != '0);

    always_comb begin
        returnedValue = '0;
        for (int i = 0; i < 4; i++) begin
            depositSum[i] = {1'b0, store[i]} + {1'b0, deposit[i]};
            returnedValue = returnedValue
                + VAL_W'(coinValue(coinType_t'(2'(i)))) * VAL_W'(coinOut[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            store   <= initStore;
            coinOut <= '0;
        end else if (load) begin
            // Carry out of the widened sum means the counter saturates at all-ones.
            for (int i = 0; i < 4; i++)
                store[i] <= depositSum[i][COIN_W] ? '1 : depositSum[i][COIN_W-1:0];
            coinOut <= '0;
        end else if (giveBack) begin
            for (int i = 0; i < 4; i++)
                store[i] <= store[i] + coinOut[i];
            coinOut <= '0;
        end else if (dispense) begin
            store[coinSel]   <= store[coinSel] - COIN_W'(1);
            coinOut[coinSel] <= coinOut[coinSel] + COIN_W'(1);
        end
    end

endmodule

// File: rtl/vending_machine_gen.sv
// rtl/vending_machine_gen.sv - vending controller FSM and pricing; VENDING_STOCK_EN adds per-item stock
module vending_machine_gen
    import vending_pkg::*;
#(
    parameter int COIN_W = 6,
    parameter int NUM_W  = 3,
    parameter int VAL_W  = 13,
    parameter int INIT_A = 5,
    parameter int INIT_B = 30,
    parameter int INIT_C = 10,
    parameter int INIT_D = 20
`ifdef VENDING_STOCK_EN
    ,
    parameter int STOCK_INIT = 7
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COIN_W-1:0] coin_in_a,
    input  logic [COIN_W-1:0] coin_in_b,
    input  logic [COIN_W-1:0] coin_in_c,
    input  logic [COIN_W-1:0] coin_in_d,
    input  logic [1:0]        item_type_in,
    input  logic [NUM_W-1:0]  item_number_in,
    input  logic              force_in,
    output logic [COIN_W-1:0] coin_out_a,
    output logic [COIN_W-1:0] coin_out_b,
    output logic [COIN_W-1:0] coin_out_c,
    output logic [COIN_W-1:0] coin_out_d,
    output logic [1:0]        item_type_out,
    output logic [NUM_W-1:0]  item_number_out,
    output logic [1:0]        service_type_out,
    output logic              done
);

    state_t                 state;
    coinType_t              coinIdx;
    logic                   forceLat, accept, step, giveBack, dispense;
    logic [NUM_W-1:0]       grantNum;
    logic [VAL_W-1:0]       inputValue, serviceValue, depositValue, orderValue;
    logic [VAL_W-1:0]       cost, curCoinValue, returnedValue;
    logic [3:0][COIN_W-1:0] deposit, coinOut;

    assign req_ready    = (service_type_out == SVC_ON);
    assign accept       = req_ready && req_valid && (item_number_in != '0);
    assign deposit      = {coin_in_d, coin_in_c, coin_in_b, coin_in_a};
    assign depositValue = VAL_W'(coin_in_a) * VAL_W'(VALUE_A) + VAL_W'(coin_in_b) * VAL_W'(VALUE_B)
                        + VAL_W'(coin_in_c) * VAL_W'(VALUE_C) + VAL_W'(coin_in_d) * VAL_W'(VALUE_D);
    assign orderValue   = VAL_W'(grantNum) * VAL_W'(itemCost(itemType_t'(item_type_in)));
    assign cost         = VAL_W'(itemCost(itemType_t'(item_type_out)));
    assign curCoinValue = VAL_W'(coinValue(coinIdx));
    assign step         = (state == ST_CHANGE);
    assign giveBack     = step && (coinIdx == COIN_D) && (serviceValue != '0) && !dispense;

    assign coin_out_a = coinOut[0];
    assign coin_out_b = coinOut[1];
    assign coin_out_c = coinOut[2];
    assign coin_out_d = coinOut[3];

`ifdef VENDING_STOCK_EN
    logic [3:0][NUM_W-1:0] stock;

    assign grantNum = (item_number_in < stock[item_type_in]) ? item_number_in : stock[item_type_in];

    always_ff @(posedge clk) begin
        if (!reset)
            stock <= {4{NUM_W'(STOCK_INIT)}};
        else if (state == ST_OFF)
            stock[item_type_out] <= stock[item_type_out] - item_number_out;
    end
`else
    assign grantNum = item_number_in;
`endif

    vending_change_unit #(
        .COIN_W(COIN_W), .VAL_W(VAL_W),
        .INIT_A(INIT_A), .INIT_B(INIT_B), .INIT_C(INIT_C), .INIT_D(INIT_D)
    ) changeUnit (
        .clk(clk), .reset(reset), .load(accept), .deposit(deposit),
        .step(step), .giveBack(giveBack), .coinSel(coinIdx),
        .serviceValue(serviceValue), .dispense(dispense),
        .coinOut(coinOut), .returnedValue(returnedValue)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= ST_ON;
            service_type_out <= SVC_ON;
            done             <= 1'b0;
            item_type_out    <= '0;
            item_number_out  <= '0;
            forceLat         <= 1'b0;
            coinIdx          <= COIN_A;
            inputValue       <= '0;
            serviceValue     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_ON: if (accept) begin
                    item_type_out    <= item_type_in;
                    item_number_out  <= grantNum;
                    forceLat         <= force_in;
                    inputValue       <= depositValue;
                    serviceValue     <= orderValue;
                    coinIdx          <= COIN_A;
                    state            <= ST_PRICE;
                    service_type_out <= SVC_BUSY;
                end
                ST_PRICE: begin
                    // Forced orders shed one item per cycle until affordable.
                    if (inputValue >= serviceValue) begin
                        serviceValue <= inputValue - serviceValue;
                        state        <= ST_CHANGE;
                    end else if (forceLat) begin
                        item_number_out <= item_number_out - NUM_W'(1);
                        serviceValue    <= serviceValue - cost;
                    end else begin
                        serviceValue    <= inputValue;
                        item_number_out <= '0;
                        state           <= ST_CHANGE;
                    end
                end
                ST_CHANGE: begin
                    if (dispense)
                        serviceValue <= serviceValue - curCoinValue;
                    else if (coinIdx != COIN_D)
                        coinIdx <= coinType_t'(coinIdx + 2'd1);
                    else if (serviceValue == '0) begin
                        state            <= ST_OFF;
                        service_type_out <= SVC_OFF;
                        done             <= 1'b1;
                    end else begin
                        // Change cannot be made: coins go back to the store, retry from coin A.
                        coinIdx <= COIN_A;
                        if (forceLat && item_number_out != '0) begin
                            item_number_out <= item_number_out - NUM_W'(1);
                            serviceValue    <= returnedValue + serviceValue + cost;
                        end else begin
                            serviceValue    <= inputValue;
                            item_number_out <= '0;
                        end
                    end
                end
                default: begin
                    state            <= ST_ON;
                    service_type_out <= SVC_ON;
                end
            endcase
        end
    end

endmodule
